// File: rtl/aes_dec_pkg.sv
// Shared definitions for the iterative AES decryptor: FSM encoding, the
// AES-128 round count, the FIPS-197 inverse S-box and GF(2^8) helpers.
package aes_dec_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int NR_AES128 = 10;

  // Inverse S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational inverse S-box lookup, one byte.
module inv_sbox
  import aes_dec_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = INV_SBOX[11'd2047 - {in_i, 3'b000} -: 8];

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES decryptor, one round per clock. The key store is external
// and answers rk_idx combinationally on rk_in.
// Optional feature: define AES_DEC_BLKCNT_EN to add the 16-bit blk_cnt
// output counting output handshakes.
module aes_dec_iter
  import aes_dec_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_out,
  output logic         busy
`ifdef AES_DEC_BLKCNT_EN
  ,output logic [15:0] blk_cnt
`endif
);

  state_e         fsm_q, fsm_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   st_q, st_d;
  logic [127:0]   shifted;
  logic [127:0]   subbed;
  logic [127:0]   added;
  logic [127:0]   mixed;

  // One column through InvMixColumns; row 0 sits in the top byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m [4];
    logic [31:0] res;
    for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        res[31-8*r -: 8] = res[31-8*r -: 8] ^ gmul(a[j], m[(j - r + 4) % 4]);
      end
    end
    return res;
  endfunction

  // InvShiftRows: byte (row r, column c) comes from column c-r.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = st_q[127-8*(4*((c + 4 - r) % 4)+r) -: 8];
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .in_i  (shifted[127-8*g -: 8]),
      .out_o (subbed[127-8*g -: 8])
    );
  end

  assign added = subbed ^ rk_in;

  // InvMixColumns over the four columns of the key-added state.
  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_col(added[127-32*c -: 32]);
    end
  end

  // Next-state, datapath select and handshake outputs.
  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    st_d      = st_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = 4'd0;
    unique case (fsm_q)
      S_IDLE: begin
        in_ready = 1'b1;
        rk_idx   = 4'(NR);
        if (in_valid) begin
          st_d  = cipher_in ^ rk_in;
          cnt_d = 4'(NR - 1);
          fsm_d = S_ROUND;
        end
      end
      S_ROUND: begin
        busy   = 1'b1;
        rk_idx = cnt_q;
        if (cnt_q == 4'd0) begin
          st_d  = added;
          fsm_d = S_DONE;
        end else begin
          st_d  = mixed;
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  assign plain_out = st_q;

  // State register; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
      cnt_q <= 4'd0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

`ifdef AES_DEC_BLKCNT_EN
  // Count completed output handshakes, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_cnt <= 16'd0;
    else if (out_valid && out_ready) blk_cnt <= blk_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed bench for aes_dec_iter using the FIPS-197 C.1 and Appendix B
// vectors with their published key schedules.
module tb_aes_dec_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cipher_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plain_out;
  logic         busy;
`ifdef AES_DEC_BLKCNT_EN
  logic [15:0]  blk_cnt;
  int           hs_model;
`endif

  int tests = 0;
  int fails = 0;
  bit ks_sel = 1'b0;

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic [127:0] ks_c1 [0:10] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};

  logic [127:0] ks_b [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  // Key store model: combinational lookup of the requested round key.
  always_comb begin
    rk_in = '0;
    if (rk_idx <= 4'd10) rk_in = ks_sel ? ks_b[rk_idx] : ks_c1[rk_idx];
  end

  always #5 clk = ~clk;

  aes_dec_iter #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cipher_in (cipher_in),
    .rk_idx    (rk_idx),
    .rk_in     (rk_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plain_out (plain_out),
    .busy      (busy)
`ifdef AES_DEC_BLKCNT_EN
    ,.blk_cnt  (blk_cnt)
`endif
  );

`ifdef AES_DEC_BLKCNT_EN
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hs_model <= 0;
    else if (out_valid && out_ready) hs_model <= hs_model + 1;
  end
`endif

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] ct;
    bit           sel;
    logic [127:0] pt;
    bit           garbage;
    int           hold;
  } vec_t;

  // One block: accept, run rounds, check latency/rk_idx/result, then handshake.
  task automatic do_block(input vec_t v, input string nm);
    int n;
    bit rk_ok;
    bit stable;
    @(negedge clk);
    ks_sel = v.sel;
    chk({nm, "_rk_idle"}, 128'(rk_idx), 128'd10);
    chk({nm, "_in_ready_idle"}, 128'(in_ready), 128'd1);
    in_valid  = 1'b1;
    cipher_in = v.ct;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    cipher_in = '0;
    n = 1;
    rk_ok = 1'b1;
    while (!out_valid && n < 40) begin
      if (rk_idx != 4'(10 - n)) rk_ok = 1'b0;
      if (in_ready) rk_ok = 1'b0;
      if (v.garbage) begin
        in_valid  = 1'($urandom_range(0, 1));
        cipher_in = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({nm, "_latency_edges"}, 128'(n), 128'd11);
    chk({nm, "_rk_seq"}, 128'(rk_ok), 128'd1);
    chk({nm, "_plain"}, plain_out, v.pt);
    chk({nm, "_rk_done"}, 128'(rk_idx), 128'd0);
    chk({nm, "_busy_done"}, 128'(busy), 128'd1);
    if (v.hold > 0) begin
      stable = 1'b1;
      repeat (v.hold) begin
        @(posedge clk); #1;
        if (plain_out !== v.pt || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
      end
      chk({nm, "_hold_stable"}, 128'(stable), 128'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_post_in_ready"}, 128'(in_ready), 128'd1);
    chk({nm, "_post_out_valid"}, 128'(out_valid), 128'd0);
    chk({nm, "_post_busy"}, 128'(busy), 128'd0);
  endtask

  vec_t vecs [4];

  initial begin
    int acc_t [3];
    int nacc;
    int nout;
    int t;
    bit b2b_ok;

    vecs[0] = '{ct: C1_CT, sel: 1'b0, pt: C1_PT, garbage: 1'b0, hold: 0};
    vecs[1] = '{ct: B_CT,  sel: 1'b1, pt: B_PT,  garbage: 1'b0, hold: 0};
    vecs[2] = '{ct: C1_CT, sel: 1'b0, pt: C1_PT, garbage: 1'b1, hold: 0};
    vecs[3] = '{ct: B_CT,  sel: 1'b1, pt: B_PT,  garbage: 1'b0, hold: 20};

    rst_n = 1'b0; in_valid = 1'b0; cipher_in = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd10);
    chk("rst_plain", plain_out, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) do_block(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: in_valid held high for three blocks, consumer always ready.
    @(negedge clk);
    ks_sel = 1'b0; cipher_in = C1_CT; in_valid = 1'b1; out_ready = 1'b1;
    nacc = 0; nout = 0; t = 0; b2b_ok = 1'b1;
    while (nout < 3 && t < 80) begin
      if (nacc == 3) in_valid = 1'b0;
      if (in_valid && in_ready) begin
        acc_t[nacc] = t;
        nacc++;
      end
      if (out_valid && out_ready) begin
        nout++;
        if (plain_out !== C1_PT) b2b_ok = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_outputs", 128'(nout), 128'd3);
    chk("b2b_data", 128'(b2b_ok), 128'd1);
    chk("b2b_gap1", 128'(acc_t[1] - acc_t[0]), 128'd12);
    chk("b2b_gap2", 128'(acc_t[2] - acc_t[1]), 128'd12);

    // Reset pulse in the middle of round processing.
    @(negedge clk);
    ks_sel = 1'b0; in_valid = 1'b1; cipher_in = C1_CT;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", 128'(busy), 128'd1);
    chk("mid_rk_idx", 128'(rk_idx), 128'd4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 128'(in_ready), 128'd1);
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_rk_idx", 128'(rk_idx), 128'd10);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_in_ready", 128'(in_ready), 128'd1);
    chk("after_rst_out_valid", 128'(out_valid), 128'd0);
    do_block(vecs[0], "after_rst");

`ifdef AES_DEC_BLKCNT_EN
    chk("blk_cnt", 128'(blk_cnt), 128'(hs_model[15:0]));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
